// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// =============================================================================
// dmem_bus_ctrl : CPU data-side decoder for RAM / IO / unmapped, with IO timeout
// Rev 1.0
// =============================================================================
module dmem_bus_ctrl #(
   parameter int          RAM_AW  = 12,
   parameter logic [31:0] IO_BASE = 32'hFFFF_FF00,
   parameter int          TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_wr,
   input  logic [3:0]        cpu_en,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic [3:0]        ram_we,
   output logic              ram_en,
   input  logic [31:0]       ram_rdata,
   output logic              io_req,
   output logic              io_we,
   output logic [7:0]        io_addr,
   output logic [31:0]       io_wdata,
   output logic [3:0]        io_be,
   input  logic              io_ack,
   input  logic [31:0]       io_rdata,
   input  logic              err_clr,
   output logic              bus_err,
   output logic [31:0]       err_addr
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RAM_RD  = 2'd1,
      S_IO_WAIT = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [31:0] C_BAD_DATA = 32'hDEAD_BEEF;
   localparam logic [7:0]  C_CNT_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic [31:0] r_rdata;
   logic [7:0]  r_cnt;

   logic w_access;
   logic w_write;
   logic w_hit_ram;
   logic w_hit_io;
   logic w_raise;

   assign w_access  = |cpu_en;
   assign w_write   = |cpu_wr;
   assign w_hit_ram = (cpu_addr[31:RAM_AW+2] == '0);
   assign w_hit_io  = (cpu_addr[31:8] == IO_BASE[31:8]);

   assign ram_addr  = cpu_addr[RAM_AW+1:2];
   assign ram_wdata = cpu_wdata;
   // RAM read data arrives one cycle after the strobe and is forwarded straight through
   assign cpu_rdata = (r_state == S_RAM_RD) ? ram_rdata : r_rdata;

   always_comb begin
      cpu_stall = 1'b0;
      ram_en    = 1'b0;
      ram_we    = '0;
      w_raise   = 1'b0;
      if (rst) begin
         if (r_state == S_IDLE && w_access) begin
            if (w_hit_ram) begin
               ram_en = 1'b1;
               if (w_write) ram_we = cpu_wr & cpu_en;
               else         cpu_stall = 1'b1;
            end else begin
               cpu_stall = 1'b1;
               w_raise   = !w_hit_io;
            end
         end else if (r_state == S_IO_WAIT) begin
            cpu_stall = 1'b1;
            // an ack in the final wait cycle takes precedence over the timeout
            w_raise   = !io_ack && (r_cnt == C_CNT_LAST);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_rdata  <= '0;
         r_cnt    <= '0;
         io_req   <= 1'b0;
         io_we    <= 1'b0;
         io_addr  <= '0;
         io_wdata <= '0;
         io_be    <= '0;
         bus_err  <= 1'b0;
         err_addr <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_access) begin
                  if (w_hit_ram) begin
                     if (!w_write) r_state <= S_RAM_RD;
                  end else if (w_hit_io) begin
                     io_req   <= 1'b1;
                     io_we    <= w_write;
                     io_addr  <= cpu_addr[7:0];
                     io_wdata <= cpu_wdata;
                     io_be    <= cpu_en;
                     r_cnt    <= '0;
                     r_state  <= S_IO_WAIT;
                  end else begin
                     r_rdata <= C_BAD_DATA;
                     r_state <= S_DONE;
                  end
               end
            end
            S_RAM_RD: r_state <= S_IDLE;
            S_IO_WAIT: begin
               if (io_ack) begin
                  r_rdata <= io_rdata;
                  io_req  <= 1'b0;
                  r_state <= S_DONE;
               end else if (r_cnt == C_CNT_LAST) begin
                  r_rdata <= C_BAD_DATA;
                  io_req  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         if (w_raise) begin
            bus_err <= 1'b1;
            if (!bus_err) err_addr <= cpu_addr;
         end else if (err_clr) begin
            bus_err <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
